// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Target side of the MEM-stage load/store interface. Accepts one request at
//   a time, waits LATENCY cycles, then completes it with a one-cycle Ready
//   pulse. Word / halfword / byte accesses on an internal little-endian word
//   array; loads are sign-extended for halfword and byte.
//
// Parameters
//   ADDR_W   word-index width, array depth = 2**ADDR_W words
//   LATENCY  wait cycles between acceptance and response (0..15)
//
// Ports
//   Clk        clock, all state updates on the rising edge
//   Rst        synchronous active-high reset (array contents are kept)
//   Req        request valid from the MEM stage
//   Address    byte address, Address[ADDR_W+1:2] is the word index
//   WriteData  store data, right-aligned
//   MemWrite   store request
//   MemRead    load request
//   Datatype   00 word, 01 halfword, 10 byte, 11 word
//   ReadData   load result, valid only while Ready=1, otherwise 0
//   Ready      one-cycle completion pulse
//   Error      misalignment flag, valid only while Ready=1
//   Stall      Req & ~Ready, the pipeline holds while high
//   state_dbg  current FSM state (0 IDLE, 1 WAIT, 2 RESPOND)
//
// Handshake: a request is accepted on a rising edge where Req=1, MemRead or
// MemWrite is set and the responder is idle. The requester keeps Req and its
// fields stable until it sees Ready=1. Ready marks completion for exactly one
// cycle; ReadData and Error are only meaningful in that cycle.
//
// Build option
//   DMEM_BACK_TO_BACK_EN  when defined, a valid request present during the
//   RESPOND cycle is accepted on the same edge, so there is no idle gap between
//   accesses. When undefined, an IDLE cycle always follows RESPOND.

module data_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  Datatype,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Error,
  output logic        Stall,
  output logic [1:0]  state_dbg
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Lane helpers
  // ---------------------------------------------------------------------------
  function automatic logic misaligned(input logic [1:0] lo, input logic [1:0] dt);
    case (dt)
      2'b01:   misaligned = lo[0];
      2'b10:   misaligned = 1'b0;
      default: misaligned = (lo != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] lo, input logic [1:0] dt);
    case (dt)
      2'b01:   lane_be = lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   lane_be = 4'b0001 << lo;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated across all lanes; the byte enables pick the lane.
  function automatic logic [31:0] lane_data(input logic [31:0] wd, input logic [1:0] dt);
    case (dt)
      2'b01:   lane_data = {2{wd[15:0]}};
      2'b10:   lane_data = {4{wd[7:0]}};
      default: lane_data = wd;
    endcase
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  lo,
                                               input logic [1:0]  dt);
    logic [15:0] h;
    logic [7:0]  b;
    h = lo[1] ? word[31:16] : word[15:0];
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    case (dt)
      2'b01:   extract_load = {{16{h[15]}}, h};
      2'b10:   extract_load = {{24{b[7]}}, b};
      default: extract_load = word;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State and captured request
  // ---------------------------------------------------------------------------
  logic [31:0]       mem [0:DEPTH-1];

  state_t            state, state_next;
  logic [3:0]        wait_cnt, cnt_next;

  logic [ADDR_W-1:0] idx_q;
  logic [1:0]        lo_q;
  logic [31:0]       wdata_q;
  logic [1:0]        dt_q;
  logic              write_q;
  logic              read_q;
  logic              mis_q;

  // Incoming request decode
  logic [ADDR_W-1:0] in_idx;
  logic [1:0]        in_lo;
  logic              in_mis;
  logic              req_ok;
  logic              direct_rsp;
  logic              unused_addr_bits;

  assign in_idx     = Address[ADDR_W+1:2];
  assign in_lo      = Address[1:0];
  assign in_mis     = misaligned(in_lo, Datatype);
  assign req_ok     = Req & (MemRead | MemWrite);
  // Misaligned requests skip the wait entirely; LATENCY=0 never waits.
  assign direct_rsp = in_mis || (LATENCY == 0);
  // Address bits above the index are deliberately ignored (index wraps).
  assign unused_addr_bits = ^Address[31:ADDR_W+2];

  // Commit of the captured store happens on the edge that leaves RESPOND.
  logic        commit_now;
  logic [3:0]  commit_be;
  logic [31:0] commit_data;

  assign commit_now  = (state == ST_RESPOND) && write_q && !mis_q;
  assign commit_be   = lane_be(lo_q, dt_q);
  assign commit_data = lane_data(wdata_q, dt_q);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic capture;
  logic rsp_enter;
  logic rsp_from_input;

  always_comb begin
    state_next     = state;
    cnt_next       = wait_cnt;
    capture        = 1'b0;
    rsp_enter      = 1'b0;
    rsp_from_input = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req_ok) begin
          capture = 1'b1;
          if (direct_rsp) begin
            state_next     = ST_RESPOND;
            rsp_enter      = 1'b1;
            rsp_from_input = 1'b1;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_next = ST_RESPOND;
          rsp_enter  = 1'b1;
        end else begin
          cnt_next = wait_cnt - 4'd1;
        end
      end
      ST_RESPOND: begin
        state_next = ST_IDLE;
`ifdef DMEM_BACK_TO_BACK_EN
        if (req_ok) begin
          capture = 1'b1;
          if (direct_rsp) begin
            state_next     = ST_RESPOND;
            rsp_enter      = 1'b1;
            rsp_from_input = 1'b1;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = WAIT_INIT;
          end
        end
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Response data: prepared on the edge that enters RESPOND
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] rsp_idx;
  logic [1:0]        rsp_lo;
  logic [1:0]        rsp_dt;
  logic              rsp_mis;
  logic              rsp_is_read;
  logic [31:0]       rd_word;
  logic [31:0]       fwd_word;

  assign rsp_idx     = rsp_from_input ? in_idx   : idx_q;
  assign rsp_lo      = rsp_from_input ? in_lo    : lo_q;
  assign rsp_dt      = rsp_from_input ? Datatype : dt_q;
  assign rsp_mis     = rsp_from_input ? in_mis   : mis_q;
  // Read+write together is performed as a write and returns 0.
  assign rsp_is_read = rsp_from_input ? (MemRead & ~MemWrite) : (read_q & ~write_q);

  assign rd_word = mem[rsp_idx];
  // A store committing on this same edge (back-to-back with zero latency)
  // must be visible to the load that enters RESPOND on it.
  assign fwd_word = (commit_now && (rsp_idx == idx_q))
                    ? merge_lanes(rd_word, commit_data, commit_be)
                    : rd_word;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      ReadData <= 32'd0;
      Ready    <= 1'b0;
      Error    <= 1'b0;
      idx_q    <= '0;
      lo_q     <= 2'd0;
      wdata_q  <= 32'd0;
      dt_q     <= 2'd0;
      write_q  <= 1'b0;
      read_q   <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= cnt_next;
      Ready    <= rsp_enter;
      Error    <= rsp_enter & rsp_mis;
      ReadData <= (rsp_enter && !rsp_mis && rsp_is_read)
                  ? extract_load(fwd_word, rsp_lo, rsp_dt) : 32'd0;
      if (capture) begin
        idx_q   <= in_idx;
        lo_q    <= in_lo;
        wdata_q <= WriteData;
        dt_q    <= Datatype;
        write_q <= MemWrite;
        read_q  <= MemRead;
        mis_q   <= in_mis;
      end
    end
  end

  // Array is never cleared; reset only blocks a pending commit.
  always_ff @(posedge Clk) begin
    if (!Rst && commit_now) begin
      for (int b = 0; b < 4; b++) begin
        if (commit_be[b]) mem[idx_q][8*b +: 8] <= commit_data[8*b +: 8];
      end
    end
  end

  assign Stall     = Req & ~Ready;
  assign state_dbg = state;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data memory responder: the target side of the datapath's MEM-stage load/store interface.
- Accepts one request at a time via a Req/Ready handshake.
- Performs word, halfword or byte access on an internal word array; returns load data after a programmable wait.
- Drives Stall so the pipeline holds EX/MEM and MEM/WB until the access completes.

Parameters:
- ADDR_W, 10, word-index width; array depth = 2**ADDR_W words.
- LATENCY, 2, wait cycles between acceptance and response; legal range 0..15.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  synchronous, active-high reset.
- Req  input  1  request valid from MEM stage.
- Address  input  32  byte address; Address[ADDR_W+1:2] is the word index.
- WriteData  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- MemWrite  input  1  store request.
- MemRead  input  1  load request.
- Datatype  input  2  00 word, 01 halfword, 10 byte, 11 treated as word.
- ReadData  output  32  load result, sign-extended for halfword/byte; valid only while Ready=1.
- Ready  output  1  one-cycle completion pulse.
- Error  output  1  misalignment flag; valid only while Ready=1.
- Stall  output  1  combinational Req & ~Ready; pipeline holds while high.

Behaviour:
- Reset values: ReadData=0, Ready=0, Error=0, FSM=IDLE, wait counter=0.
- Array contents are not cleared by Rst.
- FSM states: IDLE, WAIT, RESPOND.
- IDLE:
  - Req=1 with MemRead or MemWrite set latches Address, WriteData, Datatype and op.
  - Next state is WAIT, or RESPOND if LATENCY=0.
  - Req=1 with neither MemRead nor MemWrite set: ignored. Stay IDLE; Stall stays high, so the requester must not do this.
- WAIT: counter loads LATENCY-1 on entry, decrements each cycle, moves to RESPOND at 0.
- Total latency: acceptance edge to Ready = LATENCY+1 cycles.
- RESPOND: Ready=1 for exactly one cycle, then IDLE. Inputs are ignored during WAIT/RESPOND (captured copies are used).
- Write commit: occurs on the RESPOND clock edge, byte-lane masked, little-endian.
  - Halfword lane selected by Address[1].
  - Byte lane selected by Address[1:0].
- Read data:
  - Sampled from the array in RESPOND.
  - Lane extracted and sign-extended from bit 15 (halfword) or bit 7 (byte).
  - Registered onto ReadData, valid in RESPOND only; returns to 0 the cycle after.
- MemRead and MemWrite both set: performed as a write; ReadData=0.
- Misalignment (word with Address[1:0]!=0, halfword with Address[0]=1):
  - No array update.
  - Goes directly IDLE->RESPOND regardless of LATENCY.
  - Ready=1, Error=1, ReadData=0.
- Address bits above ADDR_W+1 are ignored: the index wraps modulo depth.
- Reset mid-operation: FSM returns to IDLE; a pending write is dropped (never committed); outputs take reset values.
- Read-after-write to the same word in consecutive requests returns the newly written value.

Optional Feature:
- Macro DMEM_BACK_TO_BACK_EN.
- Defined:
  - In RESPOND, if Req=1 with a valid op, the new request is latched on the same edge.
  - Next state is WAIT/RESPOND directly instead of IDLE, giving a sustained throughput of one access per LATENCY+1 cycles.
  - A write committed in RESPOND is visible to a read accepted on that edge.
- Undefined: a mandatory IDLE cycle follows every RESPOND, giving one access per LATENCY+2 cycles.

Test Plan:
- LATENCY=2, store word 0xDEADBEEF to 0x40, then load word 0x40:
  - Ready is seen 3 cycles after each acceptance.
  - ReadData=0xDEADBEEF, Error=0.
  - Stall high from Req until the Ready cycle.
- Store byte 0x80 to 0x41 over word 0x00000000, then load byte 0x41 and load word 0x40:
  - Byte load returns 0xFFFFFF80.
  - Word load returns 0x00008000.
- Store halfword 0x1234 to 0x46 over 0x00000000, then load halfword 0x46:
  - Halfword load returns 0x00001234.
  - Word load at 0x44 returns 0x12340000.
- Load word at 0x42, and store halfword at 0x43:
  - Each produces Ready and Error=1 one cycle after acceptance.
  - ReadData=0; memory unchanged.
- Store word 0xAAAA5555 to 0x10, asserting Rst during WAIT:
  - Outputs go to 0 and FSM to IDLE.
  - A subsequent load of 0x10 returns the old value.
- Address 0x1000 with ADDR_W=10: aliases word 0. With DMEM_BACK_TO_BACK_EN and Req held on 4 loads, a Ready pulse occurs every 3 cycles.
